// File: rtl/push_conditioner.sv
// push_conditioner: per-button 2-flop synchronizer, debounce FSM and level/press/release pulses.
// Define PUSH_AUTOREPEAT_EN to build hold-to-repeat; without it btn_repeat is tied to 0.
module push_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] push_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_act
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= push_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic        r_level;
    logic        w_level_nxt;
    logic        r_press;
    logic        w_press_nxt;
    logic        r_release;
    logic        w_release_nxt;
    logic        w_s;

    assign w_s = r_sync2[gi];

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            w_state_nxt = DEB_PRESS;
            w_cnt_nxt   = 24'd1;
          end
        end
        DEB_PRESS: begin
          if (!w_s) begin
            w_state_nxt = IDLE;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = HELD;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end
        HELD: begin
          if (!w_s) begin
            w_state_nxt = DEB_RELEASE;
            w_cnt_nxt   = 24'd1;
          end
        end
        DEB_RELEASE: begin
          if (w_s) begin
            w_state_nxt = HELD;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt   = IDLE;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    assign btn_level[gi]   = r_level;
    assign btn_press[gi]   = r_press;
    assign btn_release[gi] = r_release;

`ifdef PUSH_AUTOREPEAT_EN
    // Reload wraps modulo 2^24, so PERIOD > DELAY still lands on DELAY after PERIOD steps.
    localparam logic [23:0] REP_DELAY  = 24'(REPEAT_DELAY);
    localparam logic [23:0] REP_RELOAD = 24'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [23:0] r_rep_cnt;
    logic [23:0] w_rep_cnt_nxt;
    logic [23:0] w_rep_inc;
    logic        r_repeat;
    logic        w_repeat_nxt;

    assign w_rep_inc = r_rep_cnt + 24'd1;

    always_comb begin
      w_rep_cnt_nxt = r_rep_cnt;
      w_repeat_nxt  = 1'b0;
      if (w_press_nxt) begin
        w_rep_cnt_nxt = '0;
      end else if (r_state == HELD && w_s) begin
        if (w_rep_inc == REP_DELAY) begin
          w_repeat_nxt  = 1'b1;
          w_rep_cnt_nxt = REP_RELOAD;
        end else begin
          w_rep_cnt_nxt = w_rep_inc;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_rep_cnt <= '0;
        r_repeat  <= 1'b0;
      end else begin
        r_rep_cnt <= w_rep_cnt_nxt;
        r_repeat  <= w_repeat_nxt;
      end
    end

    assign btn_repeat[gi] = r_repeat;
`else
    assign btn_repeat[gi] = 1'b0;
`endif
  end

  assign btn_act = btn_press | btn_repeat;

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench for push_conditioner: directed scenarios plus randomized button
// activity, compared every cycle against a sample-history reference model.
module tb_push_conditioner;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] push_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic [N-1:0] btn_act;

  push_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .resetn(resetn), .push_raw(push_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .btn_act(btn_act)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: raw samples since reset, debounced-input history, levels, hold timers.
  logic [N-1:0] samp_q[$];
  logic [N-1:0] s_q[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] e_press;
  logic [N-1:0] e_release;
  logic [N-1:0] e_repeat;
  int           m_t[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    s_q.delete();
    m_lvl     = '0;
    e_press   = '0;
    e_release = '0;
    e_repeat  = '0;
    for (int b = 0; b < N; b++) m_t[b] = 0;
  endtask

  // The debounced decision at edge n sees the raw value sampled two edges earlier.
  // A level flips once the last D such inputs all disagree with it; the hold timer
  // advances only on edges where the input was high at this and the previous edge.
  task automatic model_step(input logic [N-1:0] v);
    logic [N-1:0] s_now;
    logic [N-1:0] s_prev;
    bit           opp;
    samp_q.push_back(v);
    s_now  = (samp_q.size() >= 3) ? samp_q[samp_q.size()-3] : '0;
    s_prev = (s_q.size() >= 1) ? s_q[s_q.size()-1] : '0;
    s_q.push_back(s_now);
    if (samp_q.size() > 8) void'(samp_q.pop_front());
    if (s_q.size() > 2*D) void'(s_q.pop_front());
    e_press   = '0;
    e_release = '0;
    e_repeat  = '0;
    for (int b = 0; b < N; b++) begin
      opp = (s_q.size() >= D);
      for (int k = 0; k < D; k++)
        if (opp && s_q[s_q.size()-1-k][b] == m_lvl[b]) opp = 1'b0;
      if (opp) begin
        m_lvl[b] = ~m_lvl[b];
        if (m_lvl[b]) begin
          e_press[b] = 1'b1;
          m_t[b]     = 0;
        end else begin
          e_release[b] = 1'b1;
        end
      end else if (m_lvl[b] && s_prev[b] && s_now[b]) begin
        m_t[b]++;
`ifdef PUSH_AUTOREPEAT_EN
        if (m_t[b] >= RD && (m_t[b] - RD) % RP == 0) e_repeat[b] = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_all();
    chk("level",   32'(btn_level),   32'(m_lvl));
    chk("press",   32'(btn_press),   32'(e_press));
    chk("release", 32'(btn_release), 32'(e_release));
    chk("repeat",  32'(btn_repeat),  32'(e_repeat));
    chk("act",     32'(btn_act),     32'(e_press | e_repeat));
    chk("press_rep_excl", 32'(btn_press & btn_repeat), 32'd0);
    chk("rel_rep_excl",   32'(btn_release & btn_repeat), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"},   32'(btn_level),   32'd0);
    chk({tag, "_press"},   32'(btn_press),   32'd0);
    chk({tag, "_release"}, 32'(btn_release), 32'd0);
    chk({tag, "_repeat"},  32'(btn_repeat),  32'd0);
    chk({tag, "_act"},     32'(btn_act),     32'd0);
  endtask

  task automatic step(input logic [N-1:0] v);
    push_raw = v;
    @(posedge clk);
    model_step(v);
    #1;
    cyc++;
    check_all();
  endtask

  // Asserts reset between edges, checks the cleared outputs, releases it just after an edge.
  task automatic apply_reset(input logic [N-1:0] v);
    push_raw = v;
    #2 resetn = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 check_zero("rst_hold");
    resetn = 1'b1;
    model_reset();
  endtask

  int           first_k;
  int           n_hit;
  logic [N-1:0] cur;
  int           dur[N];

  initial begin
    resetn   = 1'b0;
    push_raw = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset(5'h1F);

    // Buttons held through reset release: one press of all five after E5.
    first_k = -1;
    n_hit   = 0;
    for (int k = 0; k < 12; k++) begin
      step(5'h1F);
      if (btn_press == 5'h1F) begin
        if (first_k < 0) first_k = k;
        n_hit++;
      end
    end
    chk("rst_press_cycle", 32'(first_k), 32'd5);
    chk("rst_press_count", 32'(n_hit), 32'd1);

    for (int k = 0; k < 10; k++) step(5'h00);
    for (int k = 0; k < 10; k++) step(5'h01);
    for (int k = 0; k < 3; k++)  step(5'h05);
    for (int k = 0; k < 8; k++)  step(5'h01);
    for (int k = 0; k < 3; k++)  step(5'h00);
    for (int k = 0; k < 8; k++)  step(5'h01);
    chk("glitch_level2", 32'(btn_level[2]), 32'd0);
    chk("dip_level0",    32'(btn_level[0]), 32'd1);

    // Long hold on bit 4: repeats at P+10, P+13, ... within the 30 cycles after the press.
    n_hit = 0;
    for (int k = 0; k < 36; k++) begin
      step(5'h11);
      if (k >= 6 && btn_repeat[4]) n_hit++;
    end
`ifdef PUSH_AUTOREPEAT_EN
    chk("hold_repeat_count", 32'(n_hit), 32'd7);
`else
    chk("hold_repeat_count", 32'(n_hit), 32'd0);
`endif
    for (int k = 0; k < 10; k++) step(5'h01);

    for (int k = 0; k < 10; k++) step(5'h09);
    for (int k = 0; k < 10; k++) step(5'h03);
    for (int k = 0; k < 10; k++) step(5'h00);

    cur = '0;
    for (int b = 0; b < N; b++) dur[b] = $urandom_range(1, 8);
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) apply_reset(cur);
      for (int b = 0; b < N; b++) begin
        dur[b]--;
        if (dur[b] <= 0) begin
          cur[b] = ~cur[b];
          dur[b] = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 8);
        end
      end
      step(cur);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
